// File: rtl/keycode_hub_pkg.sv
// Shared constants, register map and FSM state type for the keycode event hub.
package keycode_hub_pkg;

    localparam logic [3:0] A_STAGE0     = 4'd0;
    localparam logic [3:0] A_STAGE1     = 4'd1;
    localparam logic [3:0] A_COMMIT     = 4'd2;
    localparam logic [3:0] A_STATUS     = 4'd3;
    localparam logic [3:0] A_WATCH_BASE = 4'd8;

    localparam logic [7:0] KC_ROLLOVER = 8'h01;
    localparam logic [7:0] KC_NONE     = 8'h00;

    localparam int unsigned ST_COUNT_W      = 5;
    localparam int unsigned ST_OVERFLOW_BIT = 8;
    localparam int unsigned ST_BUSY_BIT     = 9;
    localparam int unsigned ST_DROPPED_BIT  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StMatch,
        StEmit
    } hub_state_e;

    // Byte lane k of a 32-bit bus word.
    function automatic logic [7:0] slot_byte(input logic [31:0] word, input int unsigned k);
        return word[8*k +: 8];
    endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o whenever valid_o is high.
module keycode_evt_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic            pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic            valid_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign full_o  = full;
    assign count_o = count_q;

endmodule

// File: rtl/keycode_hub.sv
// Multi-key HID report engine: watch-table match, per-action held bits and a press/release FIFO.
module keycode_hub
    import keycode_hub_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 6,
    parameter int unsigned NUM_WATCH  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 avs_chipselect,
    input  logic [3:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic [7:0]           keycode_export,
    output logic [NUM_WATCH-1:0] held,
    output logic                 evt_valid,
    output logic                 evt_press,
    output logic [((NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1)-1:0] evt_idx,
    input  logic                 evt_ready,
    output logic                 irq
);

    localparam int unsigned IdxW = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]           stage_q  [NUM_SLOTS];
    logic [7:0]           report_q [NUM_SLOTS];
    logic [7:0]           prev_q   [NUM_SLOTS];
    logic [7:0]           watch_q  [NUM_WATCH];
    logic [NUM_WATCH-1:0] held_q, hnew_q, hnew;
    hub_state_e           state_q;
    logic [IdxW-1:0]      scan_q;
    logic                 overflow_q, dropped_q;
    logic [31:0]          readdata_q, rdata;

    logic                 wr_en, rd_en, commit_wr, busy, rollover;
    logic                 push, pop, ovf_set;
    logic [IdxW:0]        push_data, fifo_rdata;
    logic                 fifo_valid, fifo_full;
    logic [CntW-1:0]      fifo_count;

    assign wr_en     = avs_chipselect && avs_write;
    assign rd_en     = avs_chipselect && avs_read;
    assign commit_wr = wr_en && (avs_address == A_COMMIT);
    assign busy      = (state_q != StIdle);

    always_comb begin
        hnew     = '0;
        rollover = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (report_q[s] == KC_ROLLOVER) begin
                rollover = 1'b1;
            end
        end
        for (int i = 0; i < NUM_WATCH; i++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (watch_q[i] != KC_NONE && report_q[s] == watch_q[i]) begin
                    hnew[i] = 1'b1;
                end
            end
        end
    end

    assign push      = (state_q == StEmit) && (hnew_q[scan_q] != held_q[scan_q]);
    assign push_data = {hnew_q[scan_q], scan_q};
    assign pop       = evt_ready && fifo_valid;
    assign ovf_set   = push && fifo_full && !pop;

    keycode_evt_fifo #(
        .WIDTH(IdxW + 1),
        .DEPTH(FIFO_DEPTH),
        .CntW (CntW)
    ) u_evt_fifo (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .push_i (push),
        .wdata_i(push_data),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .valid_o(fifo_valid),
        .full_o (fifo_full),
        .count_o(fifo_count)
    );

    always_comb begin
        rdata = '0;
        case (avs_address)
            A_STAGE0, A_STAGE1: begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if ((k < 4) == (avs_address == A_STAGE0)) begin
                        rdata[8*(k%4) +: 8] = stage_q[k];
                    end
                end
            end
            A_COMMIT: rdata[0] = busy;
            A_STATUS: begin
                rdata[ST_COUNT_W-1:0]  = ST_COUNT_W'(fifo_count);
                rdata[ST_OVERFLOW_BIT] = overflow_q;
                rdata[ST_BUSY_BIT]     = busy;
                rdata[ST_DROPPED_BIT]  = dropped_q;
            end
            default: begin
                for (int i = 0; i < NUM_WATCH; i++) begin
                    if (avs_address == A_WATCH_BASE + 4'(i)) begin
                        rdata[7:0] = watch_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stage_q    <= '{default: '0};
            report_q   <= '{default: '0};
            prev_q     <= '{default: '0};
            watch_q    <= '{default: '0};
            held_q     <= '0;
            hnew_q     <= '0;
            scan_q     <= '0;
            state_q    <= StIdle;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (rd_en) begin
                readdata_q <= rdata;
            end

            if (wr_en) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (avs_address == ((k < 4) ? A_STAGE0 : A_STAGE1)) begin
                        stage_q[k] <= slot_byte(avs_writedata, k % 4);
                    end
                end
                for (int i = 0; i < NUM_WATCH; i++) begin
                    if (avs_address == A_WATCH_BASE + 4'(i)) begin
                        watch_q[i] <= avs_writedata[7:0];
                    end
                end
                if (avs_address == A_STATUS) begin
                    if (avs_writedata[ST_OVERFLOW_BIT]) overflow_q <= 1'b0;
                    if (avs_writedata[ST_DROPPED_BIT])  dropped_q  <= 1'b0;
                end
            end

            // A new overflow in the same cycle as a clear keeps the bit set.
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
            if (commit_wr && busy) begin
                dropped_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (commit_wr) begin
                        report_q <= stage_q;
                        prev_q   <= report_q;
                        state_q  <= StMatch;
                    end
                end
                StMatch: begin
                    if (rollover) begin
                        report_q <= prev_q;
                        state_q  <= StIdle;
                    end else begin
                        hnew_q  <= hnew;
                        scan_q  <= '0;
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    // held tracks the report even when the event itself is lost to overflow.
                    if (push) begin
                        held_q[scan_q] <= hnew_q[scan_q];
                    end
                    if (scan_q == IdxW'(NUM_WATCH - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign avs_readdata   = readdata_q;
    assign keycode_export = report_q[0];
    assign held           = held_q;
    assign evt_valid      = fifo_valid;
    assign evt_press      = fifo_valid & fifo_rdata[IdxW];
    assign evt_idx        = fifo_rdata[IdxW-1:0] & {IdxW{fifo_valid}};
    assign irq            = overflow_q | dropped_q;

endmodule

// File: doc/keycode_hub.md
# keycode_hub

Multi-key keyboard event engine on the SoC's Avalon-MM fabric, successor to the single-byte keycode PIO. The NIOS II USB driver writes each full HID boot report (up to NUM_SLOTS keycodes) and commits it. The block matches the report against a programmable watch table, keeps a per-action held vector for game logic, and queues press/release events in a FIFO. Two players can then hold several action keys at once without software polling.

## Interface
- NUM_SLOTS, 6, keycode slots per report (1..8)
- NUM_WATCH, 8, watch-table entries / held bits (1..8)
- FIFO_DEPTH, 16, event FIFO depth (power of 2, ≥2)

Ports:
- clk_clk  in  1  system clock; the only clock
- reset_reset  in  1  reset, synchronous, active-high
- avs_chipselect  in  1  slave select
- avs_address  in  4  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered, 1-cycle latency
- keycode_export  out  8  committed slot 0 (legacy PIO behaviour)
- held  out  NUM_WATCH  held[i]=1 while watch[i] key is down
- evt_valid  out  1  FIFO head valid
- evt_press  out  1  1=press, 0=release
- evt_idx  out  $clog2(NUM_WATCH) (min 1)  watch index of event
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready
- irq  out  1  = overflow | dropped sticky bits

## Operation
- Register map (word addr):
  - 0 STAGE0: slots 0–3, byte k = slot k.
  - 1 STAGE1: slots 4–7; bytes beyond NUM_SLOTS are ignored and read 0.
  - 2 COMMIT: any write starts a commit; reads return {31'b0, busy}.
  - 3 STATUS (read): [4:0] FIFO count, [8] overflow, [9] busy, [10] dropped. Write 1 to bit 8 or bit 10 to clear that bit.
  - 8+i WATCH[i]: [7:0] keycode; 0 disables the entry. Unmapped addresses read 0.
- FSM IDLE→MATCH→EMIT→IDLE.
  - IDLE: a COMMIT write latches the stage slots into the committed report and moves to MATCH.
  - MATCH, one cycle: hnew[i] = (watch[i]≠0) && (any committed slot == watch[i]). If any slot == 8'h01 (HID ErrorRollOver), the report is discarded: the committed report reverts to its prior value, held is unchanged, and the FSM returns to IDLE.
  - EMIT: scans i=0..NUM_WATCH-1, one index per cycle. If hnew[i]≠held[i], push {hnew[i], i} and set held[i]=hnew[i]. Return to IDLE after the last index.
- COMMIT written while busy: ignored, dropped set. Stage writes while busy are accepted and affect only the next commit.
- WATCH writes take effect at the next MATCH. held is not recomputed on a WATCH write.
- FIFO push when full: event lost, overflow set, held[i] still updated. Full with a simultaneous pop: the push succeeds.
- Empty FIFO: evt_valid=0. A pop while empty is a no-op.

## Timing
- Reset values: all registers, slots, watch table, held, FIFO pointers and sticky bits are 0. FSM is IDLE. Outputs are all 0.
- COMMIT write in cycle N: MATCH at N+1, EMIT index i at N+2+i, IDLE at N+2+NUM_WATCH. busy is 1 for cycles N+1..N+1+NUM_WATCH.
- held[i] and the FIFO push for index i update at the end of cycle N+2+i. evt_valid rises in cycle N+3+i if the FIFO was empty.
- keycode_export updates at the end of cycle N. It reverts at the end of N+1 on rollover.
- Read data is valid the cycle after avs_read && avs_chipselect.
- Reset mid-EMIT: reset wins; everything returns to reset values; no partial events survive.

## Structure
- keycode_hub_pkg holds:
  - address constants: A_STAGE0/1, A_COMMIT, A_STATUS, A_WATCH_BASE
  - KC_ROLLOVER = 8'h01, KC_NONE = 8'h00
  - state enum: IDLE/MATCH/EMIT
  - STATUS bit positions
- Sub-module keycode_evt_fifo: synchronous show-ahead FIFO, parameters WIDTH and DEPTH, with count output.

## Test plan
- WATCH0=0x04, WATCH1=0x1A. Stage {0x04,0x1A,0,…} and commit → events (press,0), (press,1) at N+3, N+4; held=2'b11 by N+3; keycode_export=0x04.
- Then commit {0x1A,0,…} → single event (release,0); held[1:0]=2'b10; FIFO count +1.
- Commit all slots =0x01 → no events; held and keycode_export are unchanged after N+1; busy clears at N+2.
- Second COMMIT at N+1 → dropped=1, irq=1; write STATUS bit10=1 → dropped=0, irq=0.
- evt_ready=0 and 17 toggle commits with FIFO_DEPTH=16 → count=16, overflow=1, held tracks the latest report; pop one while pushing → count stays 16.
- Assert reset during EMIT → next cycle held=0, evt_valid=0, busy=0, STATUS reads 0.
